// File: rtl/alu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// alu_exec_ctrl
//
// Execute-stage sequencer wrapped around the ALU. One decoded op is accepted
// per valid/ready handshake. Its operands and opcode are registered toward the
// ALU for one EXEC cycle. The ALU result, the flag update and the branch
// resolution are captured at the edge that ends EXEC. The result is then held
// until writeback accepts it. This block owns the architectural CCR
// (Z=bit0, N=bit1, C=bit2).
//
// Optional feature: define CCR_SAVE_EN to add a saved-flag register.
// With it, INT (28) saves the CCR and clears it, and RTI (26) restores it.
// Without it, INT and RTI behave as NOP.
//
// Ports
//   clk, rst_n             clock; synchronous active-low reset
//   in_valid/in_ready      decode handshake
//   in_op                  opcode
//   in_rs, in_rd           operand values
//   in_dst, in_wb          writeback index and write-enable
//   alu_op/alu_rs/alu_rd   registered opcode and operands driven to the ALU
//   alu_result/alu_ccr     ALU result and next-flag value
//   alu_jump               ALU branch-condition signal
//   ccr                    architectural flag register
//   jump_taken             one-cycle pulse when a branch resolves taken
//   out_valid/out_ready    writeback handshake
//   out_result/out_dst     captured result and destination index
//   out_wb                 captured write-enable
// -----------------------------------------------------------------------------
module alu_exec_ctrl #(
   parameter int DW  = 16,
   parameter int OPW = 5,
   parameter int RW  = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [OPW-1:0] in_op,
   input  logic [DW-1:0]  in_rs,
   input  logic [DW-1:0]  in_rd,
   input  logic [RW-1:0]  in_dst,
   input  logic           in_wb,
   output logic [OPW-1:0] alu_op,
   output logic [DW-1:0]  alu_rs,
   output logic [DW-1:0]  alu_rd,
   input  logic [DW-1:0]  alu_result,
   input  logic [2:0]     alu_ccr,
   input  logic           alu_jump,
   output logic [2:0]     ccr,
   output logic           jump_taken,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [DW-1:0]  out_result,
   output logic [RW-1:0]  out_dst,
   output logic           out_wb
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;

   localparam logic [OPW-1:0] OP_NOT = OPW'(1);
   localparam logic [OPW-1:0] OP_DEC = OPW'(5);
   localparam logic [OPW-1:0] OP_ADD = OPW'(9);
   localparam logic [OPW-1:0] OP_SHR = OPW'(14);
   localparam logic [OPW-1:0] OP_JZ  = OPW'(20);
   localparam logic [OPW-1:0] OP_JC  = OPW'(22);
   localparam logic [OPW-1:0] OP_JMP = OPW'(23);
`ifdef CCR_SAVE_EN
   localparam logic [OPW-1:0] OP_RTI = OPW'(26);
   localparam logic [OPW-1:0] OP_INT = OPW'(28);
`endif

   state_t         state_q, state_d;
   logic [OPW-1:0] alu_op_q, alu_op_d;
   logic [DW-1:0]  alu_rs_q, alu_rs_d;
   logic [DW-1:0]  alu_rd_q, alu_rd_d;
   logic [RW-1:0]  pend_dst_q, pend_dst_d;   // dst/wb of the op currently in EXEC
   logic           pend_wb_q, pend_wb_d;
   logic [2:0]     ccr_q, ccr_d;
   logic           jump_taken_q, jump_taken_d;
   logic           out_valid_q, out_valid_d;
   logic [DW-1:0]  out_result_q, out_result_d;
   logic [RW-1:0]  out_dst_q, out_dst_d;
   logic           out_wb_q, out_wb_d;
`ifdef CCR_SAVE_EN
   logic [2:0]     saved_q, saved_d;
`endif

   logic accept;
   logic is_flag_op;
   logic is_cond_br;
   logic is_branch;

   assign in_ready = (state_q == S_IDLE) || (state_q == S_HOLD && out_ready);
   assign accept   = in_valid && in_ready;

   // Opcode classes are decoded from the registered opcode, i.e. the op in EXEC.
   assign is_cond_br = (alu_op_q >= OP_JZ) && (alu_op_q <= OP_JC);
   assign is_branch  = is_cond_br || (alu_op_q == OP_JMP);
   assign is_flag_op = ((alu_op_q >= OP_NOT) && (alu_op_q <= OP_DEC)) ||
                       ((alu_op_q >= OP_ADD) && (alu_op_q <= OP_SHR)) ||
                       is_cond_br;

   always_comb begin
      // NOTE: every signal gets a default first, so no path can leave it
      // unassigned and infer a latch.
      state_d      = state_q;
      alu_op_d     = alu_op_q;
      alu_rs_d     = alu_rs_q;
      alu_rd_d     = alu_rd_q;
      pend_dst_d   = pend_dst_q;
      pend_wb_d    = pend_wb_q;
      ccr_d        = ccr_q;
      jump_taken_d = 1'b0;
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      out_dst_d    = out_dst_q;
      out_wb_d     = out_wb_q;
`ifdef CCR_SAVE_EN
      saved_d      = saved_q;
`endif

      case (state_q)
         S_IDLE: if (accept) state_d = S_EXEC;
         S_EXEC: begin
            out_result_d = alu_result;
            out_dst_d    = pend_dst_q;
            out_wb_d     = pend_wb_q && !is_branch;  // branches retire without a write
            out_valid_d  = 1'b1;
            jump_taken_d = (is_cond_br && alu_jump) || (alu_op_q == OP_JMP);
            if (is_flag_op) ccr_d = alu_ccr;
`ifdef CCR_SAVE_EN
            else if (alu_op_q == OP_INT) begin
               saved_d = ccr_q;
               ccr_d   = 3'b000;
            end
            else if (alu_op_q == OP_RTI) ccr_d = saved_q;
`endif
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = in_valid ? S_EXEC : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Acceptance only happens in IDLE or HOLD, so this never disturbs EXEC.
      if (accept) begin
         alu_op_d   = in_op;
         alu_rs_d   = in_rs;
         alu_rd_d   = in_rd;
         pend_dst_d = in_dst;
         pend_wb_d  = in_wb;
      end
   end

   // NOTE: state is updated only with non-blocking assignments, so every flop
   // samples the values from before the edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         alu_op_q     <= '0;
         alu_rs_q     <= '0;
         alu_rd_q     <= '0;
         pend_dst_q   <= '0;
         pend_wb_q    <= 1'b0;
         ccr_q        <= 3'b000;
         jump_taken_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_dst_q    <= '0;
         out_wb_q     <= 1'b0;
`ifdef CCR_SAVE_EN
         saved_q      <= 3'b000;
`endif
      end else begin
         state_q      <= state_d;
         alu_op_q     <= alu_op_d;
         alu_rs_q     <= alu_rs_d;
         alu_rd_q     <= alu_rd_d;
         pend_dst_q   <= pend_dst_d;
         pend_wb_q    <= pend_wb_d;
         ccr_q        <= ccr_d;
         jump_taken_q <= jump_taken_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_dst_q    <= out_dst_d;
         out_wb_q     <= out_wb_d;
`ifdef CCR_SAVE_EN
         saved_q      <= saved_d;
`endif
      end
   end

   assign alu_op     = alu_op_q;
   assign alu_rs     = alu_rs_q;
   assign alu_rd     = alu_rd_q;
   assign ccr        = ccr_q;
   assign jump_taken = jump_taken_q;
   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_dst    = out_dst_q;
   assign out_wb     = out_wb_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_ctrl
//
// Scoreboard bench for alu_exec_ctrl. A stub ALU computes
// result = (alu_rs + alu_rd) ^ alu_op, so the result reflects the registered
// operands and opcode. Each vector supplies the stub flag and jump values and
// the hand-computed expected retirement. The driver pushes the expectation at
// acceptance. The monitor compares every cycle that out_valid is high and pops
// at the writeback handshake. Build with CCR_SAVE_EN to check INT/RTI save and
// restore.
// -----------------------------------------------------------------------------
module tb_alu_exec_ctrl;
   localparam int DW = 16, OPW = 5, RW = 3;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid, in_ready;
   logic [OPW-1:0] in_op;
   logic [DW-1:0]  in_rs, in_rd;
   logic [RW-1:0]  in_dst;
   logic           in_wb;
   logic [OPW-1:0] alu_op;
   logic [DW-1:0]  alu_rs, alu_rd, alu_result;
   logic [2:0]     alu_ccr;
   logic           alu_jump;
   logic [2:0]     ccr;
   logic           jump_taken, out_valid, out_ready, out_wb;
   logic [DW-1:0]  out_result;
   logic [RW-1:0]  out_dst;

   always #5 clk = ~clk;

   alu_exec_ctrl #(.DW(DW), .OPW(OPW), .RW(RW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_rs(in_rs), .in_rd(in_rd), .in_dst(in_dst), .in_wb(in_wb),
      .alu_op(alu_op), .alu_rs(alu_rs), .alu_rd(alu_rd),
      .alu_result(alu_result), .alu_ccr(alu_ccr), .alu_jump(alu_jump),
      .ccr(ccr), .jump_taken(jump_taken),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_dst(out_dst), .out_wb(out_wb)
   );

   assign alu_result = (alu_rs + alu_rd) ^ DW'(alu_op);

`ifdef CCR_SAVE_EN
   localparam logic [2:0] INT_CCR = 3'b000, RTI_CCR = 3'b110;
`else
   localparam logic [2:0] INT_CCR = 3'b110, RTI_CCR = 3'b011;
`endif

   typedef struct {
      logic [DW-1:0] result;
      logic [RW-1:0] dst;
      logic          wb;
      logic [2:0]    ccr;
      logic          jump;
   } exp_t;

   typedef struct {
      logic [OPW-1:0] op;
      logic [DW-1:0]  rs, rd;
      logic [RW-1:0]  dst;
      logic           wb;
      logic [2:0]     s_ccr;   // stub alu_ccr
      logic           s_jump;  // stub alu_jump
      logic [DW-1:0]  e_res;
      logic           e_wb;
      logic [2:0]     e_ccr;
      logic           e_jump;
   } vec_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   logic prev_ov = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // Presents one op and waits (bounded) for acceptance. The stub ALU response
   // is applied right after the accept edge and stays valid through EXEC.
   task automatic issue(input vec_t v, output int waits);
      in_op = v.op; in_rs = v.rs; in_rd = v.rd; in_dst = v.dst; in_wb = v.wb;
      in_valid = 1'b1;
      waits = 0;
      @(negedge clk);
      while (!in_ready && waits < 50) begin
         waits++;
         @(negedge clk);
      end
      if (!in_ready) begin
         check("accept_timeout", {31'd0, in_ready}, 32'd1);
         @(posedge clk); #1;
         in_valid = 1'b0;
      end else begin
         sb_q.push_back('{v.e_res, v.dst, v.e_wb, v.e_ccr, v.e_jump});
         @(posedge clk); #1;
         in_valid = 1'b0;
         alu_ccr  = v.s_ccr;
         alu_jump = v.s_jump;
      end
   endtask

   // Monitor: compare the held output against the scoreboard head.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid) begin
            if (sb_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_out: got result %0h with empty scoreboard", out_result);
            end else begin
               check("out_result", 32'(out_result), 32'(sb_q[0].result));
               check("out_dst",    32'(out_dst),    32'(sb_q[0].dst));
               check("out_wb",     32'(out_wb),     32'(sb_q[0].wb));
               check("ccr",        32'(ccr),        32'(sb_q[0].ccr));
               if (!prev_ov) check("jump_taken", 32'(jump_taken), 32'(sb_q[0].jump));
               else          check("jump_hold",  32'(jump_taken), 32'd0);
               if (out_ready) void'(sb_q.pop_front());
            end
         end else begin
            check("jump_idle", 32'(jump_taken), 32'd0);
         end
         prev_ov = out_valid;
      end
   end

   initial begin
      vec_t tbl[$];
      vec_t v_add;
      int   waits;

      rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      in_op = 5'd9; in_rs = '0; in_rd = '0; in_dst = '0; in_wb = 1'b1;
      alu_ccr = 3'b000; alu_jump = 1'b0;

      // Reset held two cycles while decode is presenting an op.
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_ccr",       32'(ccr),       32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_alu_op",    32'(alu_op),    32'd0);
      check("rst_out_res",   32'(out_result), 32'd0);
      @(posedge clk); #1;

      // ADD 7FFF+0001 under backpressure: (8000 ^ 9) = 8009.
      v_add = '{5'd9, 16'h7FFF, 16'h0001, 3'd3, 1'b1, 3'b010, 1'b0, 16'h8009, 1'b1, 3'b010, 1'b0};
      issue(v_add, waits);
      out_ready = 1'b0;
      for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;

      //            op      rs        rd        dst   wb    s_ccr   s_j   e_res     e_wb  e_ccr   e_j
      tbl.push_back('{5'd10, 16'h0005, 16'h0003, 3'd5, 1'b1, 3'b001, 1'b0, 16'h0002, 1'b1, 3'b001, 1'b0}); // SUB
      tbl.push_back('{5'd20, 16'h0000, 16'h0000, 3'd1, 1'b1, 3'b000, 1'b1, 16'h0014, 1'b0, 3'b000, 1'b1}); // JZ taken
      tbl.push_back('{5'd20, 16'h0002, 16'h0003, 3'd1, 1'b1, 3'b000, 1'b0, 16'h0011, 1'b0, 3'b000, 1'b0}); // JZ not taken
      tbl.push_back('{5'd23, 16'h0100, 16'h0000, 3'd6, 1'b1, 3'b111, 1'b0, 16'h0117, 1'b0, 3'b000, 1'b1}); // JMP
      tbl.push_back('{5'd2,  16'h0000, 16'h0000, 3'd2, 1'b1, 3'b100, 1'b0, 16'h0002, 1'b1, 3'b100, 1'b0}); // SETC
      tbl.push_back('{5'd0,  16'h1234, 16'h1111, 3'd7, 1'b1, 3'b011, 1'b0, 16'h2345, 1'b1, 3'b100, 1'b0}); // NOP
      tbl.push_back('{5'd3,  16'h0000, 16'h0000, 3'd2, 1'b1, 3'b000, 1'b0, 16'h0003, 1'b1, 3'b000, 1'b0}); // CLRC
      tbl.push_back('{5'd5,  16'h0001, 16'hFFFF, 3'd4, 1'b1, 3'b110, 1'b0, 16'h0005, 1'b1, 3'b110, 1'b0}); // DEC
      tbl.push_back('{5'd28, 16'h0000, 16'h0000, 3'd0, 1'b0, 3'b001, 1'b0, 16'h001C, 1'b0, INT_CCR, 1'b0}); // INT
      tbl.push_back('{5'd9,  16'h0001, 16'h0001, 3'd1, 1'b1, 3'b011, 1'b0, 16'h000B, 1'b1, 3'b011, 1'b0}); // ADD
      tbl.push_back('{5'd26, 16'h0000, 16'h0000, 3'd0, 1'b0, 3'b001, 1'b0, 16'h001A, 1'b0, RTI_CCR, 1'b0}); // RTI
      tbl.push_back('{5'd31, 16'h0000, 16'h0000, 3'd5, 1'b1, 3'b111, 1'b0, 16'h001F, 1'b1, RTI_CCR, 1'b0}); // unassigned

      foreach (tbl[i]) begin
         issue(tbl[i], waits);
         // The first op after the backpressure release must go in without a stall.
         if (i == 0) check("accept_on_release", 32'(waits), 32'd0);
      end

      for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
      check("drain", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
